bf_ifetch: RTL and testbench

Instruction fetch stage for the Brainfuck core. Sits between the instruction ROM and the decoder. Drives the ROM's clock-enabled, one-cycle-latency read port with a sequential PC and buffers returned opcodes in a 2-entry queue. Presents opcodes to the decoder over a valid/ready handshake and accepts PC redirects for `[`/`]` jumps.

---
 rtl/bf_ifetch_if.sv | 26 ++
 rtl/bf_ifetch.sv | 86 ++++++++
 tb/tb_bf_ifetch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bf_ifetch_if.sv
// Fetch-stage bundle: instruction-ROM read port, decoder-side opcode handshake and PC redirect.
interface bf_ifetch_if #(
   parameter int A_WIDTH = 12,
   parameter int D_WIDTH = 8
);
   logic               rom_ce;
   logic [A_WIDTH-1:0] rom_a;
   logic [D_WIDTH-1:0] rom_q;
   logic               out_valid;
   logic               out_ready;
   logic [D_WIDTH-1:0] out_insn;
   logic [A_WIDTH-1:0] out_pc;
   logic               redirect;
   logic [A_WIDTH-1:0] redirect_pc;
   logic               halted;

   modport master (
      output rom_ce, rom_a, out_valid, out_insn, out_pc, halted,
      input  rom_q, out_ready, redirect, redirect_pc
   );

   modport slave (
      input  rom_ce, rom_a, out_valid, out_insn, out_pc, halted,
      output rom_q, out_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/bf_ifetch.sv
// Brainfuck fetch: sequential-PC ROM reads into a 2-entry {insn,pc} queue; issue-to-present 2 cycles.
// Backpressure: fetch stalls once queued + in-flight reaches 2; redirect flushes, 0x00 halts fetch.
module bf_ifetch #(
   parameter int A_WIDTH = 12,
   parameter int D_WIDTH = 8
) (
   input logic         clk,
   input logic         rst_n,
   bf_ifetch_if.master bus
);

   typedef struct packed {
      logic [D_WIDTH-1:0] insn;
      logic [A_WIDTH-1:0] pc;
   } ent_t;

   logic [A_WIDTH-1:0] pc_q, pc_d;
   logic [A_WIDTH-1:0] infl_pc_q, infl_pc_d;
   logic               infl_q, infl_d;
   logic               halted_q, halted_d;
   logic [1:0]         count_q, count_d;
   ent_t               ent_q [2];
   ent_t               ent_d [2];

   logic               pop;
   logic               issue;
   logic               ret_ok;
   logic               push;
   logic [1:0]         kept;
   logic [2:0]         occ;

   always_comb begin
      pop    = (count_q != 2'd0) && bus.out_ready;
      occ    = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
      issue  = rst_n && !halted_q && !bus.redirect && (occ < 3'd2);
      // A response is only meaningful if nothing since its issue has flushed or halted the stream.
      ret_ok = infl_q && !halted_q && !bus.redirect;
      push   = ret_ok && (bus.rom_q != '0);
      kept   = count_q - {1'b0, pop};

      ent_d[0] = pop ? ent_q[1] : ent_q[0];
      ent_d[1] = ent_q[1];
      if (push && (kept == 2'd0)) ent_d[0] = {bus.rom_q, infl_pc_q};
      if (push && (kept != 2'd0)) ent_d[1] = {bus.rom_q, infl_pc_q};

      count_d   = kept + {1'b0, push};
      infl_d    = issue;
      infl_pc_d = issue ? pc_q : infl_pc_q;
      pc_d      = issue ? pc_q + A_WIDTH'(1) : pc_q;
      halted_d  = halted_q || (ret_ok && (bus.rom_q == '0));

      if (bus.redirect) begin
         count_d  = 2'd0;
         pc_d     = bus.redirect_pc;
         halted_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= '0;
         infl_pc_q <= '0;
         infl_q    <= 1'b0;
         halted_q  <= 1'b0;
         count_q   <= 2'd0;
         ent_q[0]  <= '0;
         ent_q[1]  <= '0;
      end else begin
         pc_q      <= pc_d;
         infl_pc_q <= infl_pc_d;
         infl_q    <= infl_d;
         halted_q  <= halted_d;
         count_q   <= count_d;
         ent_q[0]  <= ent_d[0];
         ent_q[1]  <= ent_d[1];
      end
   end

   assign bus.rom_ce    = issue;
   assign bus.rom_a     = pc_q;
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_insn  = ent_q[0].insn;
   assign bus.out_pc    = ent_q[0].pc;
   assign bus.halted    = halted_q;

endmodule

// File: tb/tb_bf_ifetch.sv
// Bench for bf_ifetch: expected stream is the program walked from its start address to the first 0x00.
module tb_bf_ifetch;
   localparam int AW  = 12;
   localparam int DW  = 8;
   localparam int AW3 = 3;

   typedef struct packed {
      logic [DW-1:0] insn;
      logic [AW-1:0] pc;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic rst3_n;

   bf_ifetch_if #(.A_WIDTH(AW),  .D_WIDTH(DW)) bus  ();
   bf_ifetch_if #(.A_WIDTH(AW3), .D_WIDTH(DW)) bus3 ();

   bf_ifetch #(.A_WIDTH(AW),  .D_WIDTH(DW)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
   bf_ifetch #(.A_WIDTH(AW3), .D_WIDTH(DW)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3));

   logic [DW-1:0] mem  [0:(1<<AW)-1];
   logic [DW-1:0] mem3 [0:(1<<AW3)-1];

   always @(posedge clk) if (bus.rom_ce)  bus.rom_q  <= mem[bus.rom_a];
   always @(posedge clk) if (bus3.rom_ce) bus3.rom_q <= mem3[bus3.rom_a];

   ent_t exp_q [$];
   int   n_asrt = 0;
   int   n_fail = 0;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of test, expected $finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_expect(input logic [AW-1:0] start);
      logic [AW-1:0] p;
      exp_q.delete();
      p = start;
      for (int k = 0; k < (1 << AW); k++) begin
         if (mem[p] == '0) break;
         exp_q.push_back({mem[p], p});
         p = p + AW'(1);
      end
   endtask

   task automatic step(input logic rdy, input logic redir, input logic [AW-1:0] rpc);
      ent_t got;
      ent_t want;
      bus.out_ready   = rdy;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      #1;
      if (redir) chk("ce_in_redirect", 32'(bus.rom_ce), 0);
      if (bus.out_valid && rdy) begin
         got = {bus.out_insn, bus.out_pc};
         chk("xfer_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            chk("xfer_entry", 32'(got), 32'(want));
         end
      end
      if (redir) load_expect(rpc);
      @(negedge clk);
      bus.redirect = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1'b1, 1'b0, '0);
      repeat (3) step(1'b1, 1'b0, '0);
      chk({tag, "_drained"}, 32'(exp_q.size()), 0);
      chk({tag, "_halted"}, 32'(bus.halted), 1);
   endtask

   task automatic restart(input logic [AW-1:0] dummy);
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      load_expect(dummy);
      rst_n = 1'b1;
   endtask

   task automatic load_prog1();
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      mem[0] = 8'h2B; mem[1] = 8'h3E; mem[2] = 8'h2D; mem[3] = 8'h00;
   endtask

   initial begin
      logic [5:0] pat;
      int         n;
      rst_n = 1'b0;  rst3_n = 1'b0;
      bus.out_ready  = 1'b0; bus.redirect  = 1'b0; bus.redirect_pc  = '0;
      bus3.out_ready = 1'b0; bus3.redirect = 1'b0; bus3.redirect_pc = '0;
      load_prog1();
      repeat (3) @(negedge clk);

      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_insn",  32'(bus.out_insn), 0);
      chk("rst_pc",    32'(bus.out_pc), 0);
      chk("rst_rom_a", 32'(bus.rom_a), 0);
      chk("rst_rom_ce", 32'(bus.rom_ce), 0);
      chk("rst_halted", 32'(bus.halted), 0);
      chk("rst3_valid", 32'(bus3.out_valid), 0);

      // Basic stream, ready held high.
      load_expect('0);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      #1 chk("t1_ce_E0", 32'(bus.rom_ce), 1);
      @(negedge clk);
      chk("t1_valid_E0", 32'(bus.out_valid), 0);
      chk("t1_rom_a_E0", 32'(bus.rom_a), 1);
      @(negedge clk);
      chk("t1_valid_E1", 32'(bus.out_valid), 1);
      for (int i = 0; i < 3; i++) begin
         chk("t1_no_bubble", 32'(bus.out_valid), 1);
         step(1'b1, 1'b0, '0);
      end
      drain("t1");
      for (int i = 0; i < 3; i++) begin
         chk("t1_ce_off", 32'(bus.rom_ce), 0);
         step(1'b1, 1'b0, '0);
      end

      // Backpressure: fetch must stop with two opcodes outstanding.
      restart('0);
      repeat (5) @(negedge clk);
      #1;
      chk("t2_stall_ce", 32'(bus.rom_ce), 0);
      chk("t2_stall_valid", 32'(bus.out_valid), 1);
      chk("t2_stall_pc", 32'(bus.out_pc), 0);
      @(negedge clk);
      pat = 6'b101001;
      for (int i = 0; i < 6; i++) step(pat[i], 1'b0, '0);
      for (int i = 0; i < 20; i++) step(1'(($urandom_range(0, 1))), 1'b0, '0);
      drain("t2");

      // Redirect with one queued entry accepted in the redirect cycle and one in flight.
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 8'h5B;
      mem[8] = 8'h00;
      restart('0);
      repeat (4) @(negedge clk);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 12'd5);
      chk("t3_valid_R", 32'(bus.out_valid), 0);
      chk("t3_halted_R", 32'(bus.halted), 0);
      step(1'b1, 1'b0, '0);
      chk("t3_valid_R1", 32'(bus.out_valid), 0);
      step(1'b1, 1'b0, '0);
      chk("t3_valid_R2", 32'(bus.out_valid), 1);
      chk("t3_first_pc", 32'(bus.out_pc), 5);
      drain("t3");

      // Halt at 3, then redirect back into the program.
      load_prog1();
      step(1'b1, 1'b1, '0);
      drain("t4a");
      step(1'b1, 1'b1, 12'd1);
      chk("t4_halt_clear", 32'(bus.halted), 0);
      chk("t4_expect_len", 32'(exp_q.size()), 2);
      drain("t4");

      // Narrow PC wraps without stalling.
      for (int i = 0; i < (1 << AW3); i++) mem3[i] = 8'($urandom_range(1, 255));
      rst3_n = 1'b1;
      bus3.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         chk("t5_valid", 32'(bus3.out_valid), 1);
         chk("t5_pc", 32'(bus3.out_pc), 32'(k % 8));
         chk("t5_insn", 32'(bus3.out_insn), 32'(mem3[k % 8]));
         @(negedge clk);
      end
      rst3_n = 1'b0;

      // Asynchronous reset with a full queue.
      restart('0);
      repeat (4) @(negedge clk);
      chk("t6_full_valid", 32'(bus.out_valid), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 32'(bus.out_valid), 0);
      chk("t6_async_ce", 32'(bus.rom_ce), 0);
      chk("t6_async_pc", 32'(bus.out_pc), 0);
      @(negedge clk);
      load_expect('0);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t6_restart_valid", 32'(bus.out_valid), 1);
      chk("t6_restart_pc", 32'(bus.out_pc), 0);
      drain("t6");

      // Random program, random backpressure and random redirects.
      rst_n = 1'b0;
      n = $urandom_range(20, 60);
      for (int i = 0; i < n; i++) mem[i] = 8'($urandom_range(1, 255));
      mem[n] = 8'h00;
      restart('0);
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), AW'($urandom_range(0, n - 1)));
      drain("t7");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
